fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Program-counter and fetch sequencer on the consuming end of the control decoder's Jump/Branch/BranchCond/PCTarg outputs. Holds the PC and a registered ALU flag set. Resolves conditional and unconditional branches through a 16-entry absolute-target lookup table. Runs a Start/Done program handshake and counts executed cycles for benchmarking.

Parameters:
PC_W, 10, program counter width (instruction ROM depth 2^PC_W).
TARG_W, 4, width of PCTarg index; LUT depth 2^TARG_W.
CNT_W, 16, cycle counter width.

Ports:
Clk  in  1  single clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  level; rising-edge-qualified start request (see Behaviour).
Jump  in  1  unconditional branch from decoder.
Branch  in  1  conditional branch from decoder.
BranchCond  in  2  condition code from decoder.
PCTarg  in  TARG_W  LUT index from decoder.
Halt  in  1  current instruction is halt.
FlagWe  in  1  latch ALU flags this cycle (cmp/sub).
Zero  in  1  ALU zero flag.
Neg  in  1  ALU sign flag.
LutWe  in  1  LUT write enable.
LutAddr  in  TARG_W  LUT write index.
LutData  in  PC_W  LUT write data (absolute target).
ProgCtr  out  PC_W  registered PC to instruction ROM.
Busy  out  1  high in RUN.
Done  out  1  high in DONE.
CycleCnt  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset (Reset_n=0, async): state IDLE; ProgCtr=0; flags Z=N=0; all LUT entries 0; Busy=0; Done=0; CycleCnt=0. Reset mid-RUN aborts immediately with the same values.
- States: IDLE, RUN, DONE. Busy=(state==RUN), Done=(state==DONE), both registered.
- Start is edge-qualified: start_evt = Start & ~Start_q. Start_q is a register, reset to 0.
- IDLE: ProgCtr held at 0. On start_evt, next cycle state=RUN, ProgCtr=0, CycleCnt=0.
- RUN, each cycle, priority order:
  1. Halt=1: state=DONE, ProgCtr holds.
  2. Jump=1: ProgCtr=LUT[PCTarg].
  3. Branch=1 and cond true: ProgCtr=LUT[PCTarg].
  4. Otherwise: ProgCtr=ProgCtr+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
- RUN: CycleCnt increments every cycle and saturates at 2^CNT_W-1. start_evt is ignored.
- Condition codes use registered flags: 00 EQ (Z), 01 NE (~Z), 10 LT (N), 11 GE (~N).
- FlagWe=1 latches Zero/Neg at the clock edge, in any state. A branch in the same cycle uses the old flags; there is no bypass.
- Jump and Branch both high (illegal): Jump wins.
- Jump/Branch/FlagWe are ignored outside RUN, except FlagWe latches as stated above.
- DONE: ProgCtr and CycleCnt hold. start_evt restarts: next cycle RUN, ProgCtr=0, CycleCnt=0. Flags are not cleared on restart.
- LUT write: synchronous on LutWe, any state. Read is asynchronous on PCTarg. A same-cycle write/read of the same index returns the old value; the new value is visible from the next cycle.
- Latency: decoder inputs at cycle n determine ProgCtr at cycle n+1. A taken branch has zero bubbles.

Decomposition:
- Shared package fetch_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE}.
  - condition-code constants BC_EQ=2'b00, BC_NE=2'b01, BC_LT=2'b10, BC_GE=2'b11.
  - default PC_W/TARG_W/CNT_W constants.
- One sub-module, branch_lut: 2^TARG_W x PC_W register file with one sync write port and one async read port, async active-low reset to 0.

Test Plan:
- Reset then Start pulse, no branches, Halt at cycle 5 -> ProgCtr 0,1,2,3,4,5 then holds 5; Done=1; CycleCnt=6.
- LUT[3]=0x040 written in IDLE; Jump=1, PCTarg=3 at PC=2 -> ProgCtr=0x040 next cycle.
- FlagWe with Zero=1 at PC=7; Branch=1, BranchCond=EQ, PCTarg=3 at PC=8 -> ProgCtr=0x040. Same with BranchCond=NE -> ProgCtr=9.
- FlagWe (Neg=1) and Branch LT in the same cycle with flags previously N=0 -> not taken, PC+1. On the following cycle a branch LT is taken.
- PC_W=4, run from PC=15 with no branch -> ProgCtr=0. CycleCnt forced near max -> saturates at 0xFFFF.
- Reset_n low mid-RUN at PC=0x12 -> ProgCtr=0, Busy=0, state IDLE immediately. Holding Start high after release does not restart; a new rising edge is required.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// branch condition codes, default widths and the condition evaluator.
package fetch_pkg;

    localparam int unsigned PC_W_DEF   = 10;
    localparam int unsigned TARG_W_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] BC_EQ = 2'b00;
    localparam logic [1:0] BC_NE = 2'b01;
    localparam logic [1:0] BC_LT = 2'b10;
    localparam logic [1:0] BC_GE = 2'b11;

    // Evaluate a branch condition code against the registered flags.
    function automatic logic cond_true(input logic [1:0] bc, input logic z, input logic n);
        logic res;
        case (bc)
            BC_EQ:   res = z;
            BC_NE:   res = ~z;
            BC_LT:   res = n;
            BC_GE:   res = ~n;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target table: 2^TARG_W absolute PC targets, one synchronous write
// port and one asynchronous read port. A read of an entry being written in
// the same cycle returns the old contents.
module branch_lut #(
    parameter int unsigned TARG_W = 4,
    parameter int unsigned PC_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [TARG_W-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [TARG_W-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    localparam int unsigned DEPTH = 2 ** TARG_W;

    logic [DEPTH-1:0][PC_W-1:0] mem;

    // Table storage: cleared on reset, written on we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer. Holds the PC and registered ALU
// flags, resolves jumps/branches through branch_lut, runs the Start/Done
// program handshake and counts cycles spent running (saturating).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned TARG_W = TARG_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Jump,
    input  logic              Branch,
    input  logic [1:0]        BranchCond,
    input  logic [TARG_W-1:0] PCTarg,
    input  logic              Halt,
    input  logic              FlagWe,
    input  logic              Zero,
    input  logic              Neg,
    input  logic              LutWe,
    input  logic [TARG_W-1:0] LutAddr,
    input  logic [PC_W-1:0]   LutData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCnt
);

    state_t            state;
    state_t            state_next;
    logic              start_q;
    logic              start_evt;
    logic              take;
    logic              flag_z;
    logic              flag_n;
    logic [PC_W-1:0]   lut_rdata;
    logic [PC_W-1:0]   pc_next;
    logic [CNT_W-1:0]  cnt_next;

    assign start_evt = Start & ~start_q;

    branch_lut #(
        .TARG_W (TARG_W),
        .PC_W   (PC_W)
    ) u_lut (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .we     (LutWe),
        .waddr  (LutAddr),
        .wdata  (LutData),
        .raddr  (PCTarg),
        .rdata  (lut_rdata)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start edge launches a run from IDLE or DONE, Halt ends it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_evt) state_next = ST_RUN;
            ST_RUN:  if (Halt)      state_next = ST_DONE;
            ST_DONE: if (start_evt) state_next = ST_RUN;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Next PC and cycle count; Halt > Jump > taken Branch > sequential.
    always_comb begin
        pc_next  = ProgCtr;
        cnt_next = CycleCnt;
        take     = Jump | (Branch & cond_true(BranchCond, flag_z, flag_n));
        case (state)
            ST_IDLE: begin
                pc_next  = '0;
                cnt_next = '0;
            end
            ST_RUN: begin
                if (CycleCnt != '1) begin
                    cnt_next = CycleCnt + 1'b1;
                end
                if (Halt) begin
                    pc_next = ProgCtr;
                end else if (take) begin
                    pc_next = lut_rdata;
                end else begin
                    pc_next = ProgCtr + 1'b1;
                end
            end
            ST_DONE: begin
                if (start_evt) begin
                    pc_next  = '0;
                    cnt_next = '0;
                end
            end
            default: begin
                pc_next  = '0;
                cnt_next = '0;
            end
        endcase
    end

    // Registered outputs, ALU flags and the Start edge detector.
    // Busy/Done are loaded from the next state so they track state exactly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ProgCtr  <= '0;
            CycleCnt <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            start_q  <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
        end else begin
            ProgCtr  <= pc_next;
            CycleCnt <= cnt_next;
            Busy     <= (state_next == ST_RUN);
            Done     <= (state_next == ST_DONE);
            start_q  <= Start;
            if (FlagWe) begin
                flag_z <= Zero;
                flag_n <= Neg;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random decoder traffic.
// The driver steps a rule-level model at each falling edge and queues the
// expected post-edge outputs; a monitor pops and compares after each rising edge.
module tb_fetch_unit;

    localparam int unsigned PCW   = 10;
    localparam int unsigned TW    = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned PCMOD = 1 << PCW;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start, Jump, Branch, Halt, FlagWe, Zero, Neg, LutWe;
    logic [1:0]    BranchCond;
    logic [TW-1:0] PCTarg, LutAddr;
    logic [PCW-1:0] LutData;
    logic [PCW-1:0] ProgCtr;
    logic          Busy, Done;
    logic [CW-1:0] CycleCnt;

    fetch_unit #(.PC_W(PCW), .TARG_W(TW), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Jump(Jump), .Branch(Branch),
        .BranchCond(BranchCond), .PCTarg(PCTarg), .Halt(Halt), .FlagWe(FlagWe),
        .Zero(Zero), .Neg(Neg), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done), .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned pc;
        bit          busy;
        bit          done;
        int unsigned cnt;
    } exp_t;

    exp_t q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    bit          m_running, m_finished, m_z, m_n, m_sprev;
    int unsigned m_pc, m_cnt;
    int unsigned m_lut[16];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_finished = 0; m_z = 0; m_n = 0; m_sprev = 0;
        m_pc = 0; m_cnt = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    task automatic clear_inputs();
        Start = 0; Jump = 0; Branch = 0; BranchCond = 0; PCTarg = 0; Halt = 0;
        FlagWe = 0; Zero = 0; Neg = 0; LutWe = 0; LutAddr = 0; LutData = 0;
    endtask

    // Advance to the falling edge, release reset and clear decoder inputs.
    task automatic nxt();
        @(negedge Clk);
        Reset_n = 1;
        clear_inputs();
    endtask

    // Apply the program rules to the inputs now on the pins; queue the result.
    task automatic step();
        bit          se, cond;
        int unsigned rd;
        se = Start && !m_sprev;
        rd = m_lut[PCTarg];
        case (BranchCond)
            2'd0: cond = m_z;
            2'd1: cond = !m_z;
            2'd2: cond = m_n;
            default: cond = !m_n;
        endcase
        if (m_running) begin
            if (m_cnt < CMAX) m_cnt++;
            if (Halt) begin
                m_running = 0; m_finished = 1;
            end else if (Jump || (Branch && cond)) begin
                m_pc = rd;
            end else begin
                m_pc = (m_pc + 1) % PCMOD;
            end
        end else if (se) begin
            m_running = 1; m_finished = 0; m_pc = 0; m_cnt = 0;
        end
        if (FlagWe) begin m_z = Zero; m_n = Neg; end
        if (LutWe) m_lut[LutAddr] = LutData;
        m_sprev = Start;
        q.push_back('{m_pc, m_running, m_finished, m_cnt});
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge Clk);
        clear_inputs();
        #2 Reset_n = 0;
        #1;
        chk("rst_pc", ProgCtr, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_cnt", CycleCnt, 0);
        model_reset();
        q.push_back('{0, 0, 0, 0});
    endtask

    task automatic run_plain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            nxt(); step();
        end
    endtask

    task automatic pulse_start();
        nxt(); Start = 1; step();
    endtask

    task automatic halt_now();
        nxt(); Halt = 1; step();
    endtask

    // Monitor: compare queued expectations against the DUT after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (int'(ProgCtr) != e.pc || Busy != e.busy || Done != e.done
                    || int'(CycleCnt) != e.cnt) begin
                    n_err++;
                    $display("FAIL cycle: got pc=0x%0h busy=%0b done=%0b cnt=%0d expected pc=0x%0h busy=%0b done=%0b cnt=%0d at %0t",
                             ProgCtr, Busy, Done, CycleCnt, e.pc, e.busy, e.done, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        model_reset();

        // Straight-line run, halt at PC 5
        do_reset();
        run_plain(1);
        pulse_start();
        run_plain(5);
        halt_now();
        run_plain(2);
        nxt();
        chk("halt_pc", ProgCtr, 5);
        chk("halt_done", Done, 1);
        chk("halt_cnt", CycleCnt, 6);
        step();

        // Jump through LUT[3] written in IDLE
        do_reset();
        nxt(); LutWe = 1; LutAddr = 3; LutData = 10'h040; step();
        pulse_start();
        run_plain(2);
        nxt(); Jump = 1; PCTarg = 3; step();
        nxt(); chk("jump_pc", ProgCtr, 10'h040); Halt = 1; step();

        // Branch EQ taken on flags latched the cycle before
        pulse_start();
        run_plain(7);
        nxt(); FlagWe = 1; Zero = 1; step();
        nxt(); Branch = 1; BranchCond = 2'b00; PCTarg = 3; step();
        nxt(); chk("beq_pc", ProgCtr, 10'h040); Halt = 1; step();

        // Branch NE not taken with Z=1
        pulse_start();
        run_plain(8);
        nxt(); Branch = 1; BranchCond = 2'b01; PCTarg = 3; step();
        nxt(); chk("bne_pc", ProgCtr, 9); step();

        // Flag write and LT branch in the same cycle use old flags
        nxt(); FlagWe = 1; Neg = 0; step();
        nxt(); FlagWe = 1; Neg = 1; Branch = 1; BranchCond = 2'b10; PCTarg = 3; step();
        nxt(); chk("blt_old", ProgCtr, 12); Branch = 1; BranchCond = 2'b10; PCTarg = 3; step();
        nxt(); chk("blt_new", ProgCtr, 10'h040); step();

        // Same-cycle LUT write/read returns old value; Jump beats Branch
        nxt(); LutWe = 1; LutAddr = 3; LutData = 10'h155; Jump = 1; Branch = 1;
        BranchCond = 2'b11; PCTarg = 3; step();
        nxt(); chk("lut_old", ProgCtr, 10'h040); Jump = 1; PCTarg = 3; step();
        nxt(); chk("lut_new", ProgCtr, 10'h155); step();

        // Start held high: ignored in RUN, and DONE needs a fresh rising edge
        nxt(); Start = 1; step();
        nxt(); Start = 1; Halt = 1; step();
        for (int i = 0; i < 4; i++) begin nxt(); Start = 1; step(); end
        nxt(); chk("hold_done", Done, 1); chk("hold_busy", Busy, 0); step();

        // Reset in the middle of a run at PC 0x12
        pulse_start();
        run_plain(18);
        nxt(); chk("pre_rst_pc", ProgCtr, 10'h012); step();
        do_reset();
        run_plain(3);
        pulse_start();
        run_plain(3);

        // PC wrap and cycle counter saturation
        halt_now();
        pulse_start();
        run_plain(1024);
        nxt(); chk("wrap_pc", ProgCtr, 0); step();
        run_plain(64515);
        nxt(); chk("sat_cnt", CycleCnt, 16'hFFFF); step();
        halt_now();

        // Random decoder traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                nxt();
                Start      = ($urandom_range(0, 5) == 0);
                Jump       = ($urandom_range(0, 7) == 0);
                Branch     = ($urandom_range(0, 4) == 0);
                BranchCond = 2'($urandom_range(0, 3));
                PCTarg     = 4'($urandom_range(0, 15));
                Halt       = ($urandom_range(0, 24) == 0);
                FlagWe     = ($urandom_range(0, 3) == 0);
                Zero       = 1'($urandom_range(0, 1));
                Neg        = 1'($urandom_range(0, 1));
                LutWe      = ($urandom_range(0, 5) == 0);
                LutAddr    = 4'($urandom_range(0, 15));
                LutData    = 10'($urandom_range(0, PCMOD - 1));
                step();
            end
        end

        nxt();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
